// File: rtl/wb_rr_arb_pkg.sv
// Shared constants for the Wishbone round-robin arbiter: FSM encodings,
// default parameters, bus slice widths and the rotation helper.
package wb_rr_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam int DEF_NM     = 4;
    localparam int DEF_TO_CYC = 256;
    localparam int DEF_TO_W   = 9;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    // Index of the k-th candidate after the last grant, wrapping at nm.
    function automatic int rr_idx(input int last, input int k, input int nm);
        return (last + k) % nm;
    endfunction

endpackage

// File: rtl/wb_rr_arb_pick.sv
// Combinational round-robin picker: first requester scanning upward from
// last+1 (mod NM) wins. Kept standalone so other channel arbiters can reuse it.
module wb_rr_pick
    import wb_rr_arb_pkg::*;
#(
    parameter int NM = DEF_NM,
    parameter int LW = $clog2(NM)
) (
    input  logic [NM-1:0] i_req,
    input  logic [LW-1:0] i_last,
    output logic [NM-1:0] o_onehot,
    output logic          o_any
);

    // Priority scan starting just after the previous winner.
    always_comb begin
        logic          v_found;
        logic [LW-1:0] v_idx;
        o_onehot = '0;
        v_found  = 1'b0;
        for (int k = 1; k <= NM; k++) begin
            v_idx            = LW'(rr_idx(int'(i_last), k, NM));
            o_onehot[v_idx]  = o_onehot[v_idx] | (i_req[v_idx] & ~v_found);
            v_found          = v_found | i_req[v_idx];
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/wb_rr_arb.sv
// Round-robin Wishbone B3 classic arbiter: grant locked for a master's whole
// CYC, one dead cycle between grants, per-beat watchdog that answers with ERR.
module wb_rr_arb
    import wb_rr_arb_pkg::*;
#(
    parameter int NM     = DEF_NM,
    parameter int TO_CYC = DEF_TO_CYC,
    parameter int TO_W   = DEF_TO_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NM*ADR_W-1:0] m_adr_i,
    input  logic [NM*DAT_W-1:0] m_dat_i,
    input  logic [NM*SEL_W-1:0] m_sel_i,
    input  logic [NM-1:0]       m_we_i,
    input  logic [NM-1:0]       m_cyc_i,
    input  logic [NM-1:0]       m_stb_i,
    output logic [DAT_W-1:0]    m_dat_o,
    output logic [NM-1:0]       m_ack_o,
    output logic [NM-1:0]       m_err_o,
    output logic [NM-1:0]       m_rty_o,
    output logic [ADR_W-1:0]    s_adr_o,
    output logic [DAT_W-1:0]    s_dat_o,
    output logic [SEL_W-1:0]    s_sel_o,
    output logic                s_we_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    input  logic [DAT_W-1:0]    s_dat_i,
    input  logic                s_ack_i,
    input  logic                s_err_i,
    input  logic                s_rty_i,
    output logic [NM-1:0]       gnt_o
);

    localparam int LW = $clog2(NM);

    logic [0:0]      r_state;
    logic [NM-1:0]   r_gnt;
    logic [LW-1:0]   r_last;
    logic [TO_W-1:0] r_cnt;

    logic [NM-1:0]   w_pick;
    logic            w_any;
    logic [LW-1:0]   w_g;
    logic            w_granted;
    logic            w_cyc_g;
    logic            w_stb_g;
    logic            w_resp;
    logic            w_to_hit;

    wb_rr_pick #(
        .NM (NM),
        .LW (LW)
    ) u_pick (
        .i_req    (m_cyc_i),
        .i_last   (r_last),
        .o_onehot (w_pick),
        .o_any    (w_any)
    );

    // Encode the one-hot grant into an index and AND-OR mux the granted slice.
    always_comb begin
        w_g     = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        for (int i = 0; i < NM; i++) begin
            w_g     = w_g | (r_gnt[i] ? LW'(i) : LW'(0));
            s_adr_o = s_adr_o | (m_adr_i[ADR_W*i +: ADR_W] & {ADR_W{r_gnt[i]}});
            s_dat_o = s_dat_o | (m_dat_i[DAT_W*i +: DAT_W] & {DAT_W{r_gnt[i]}});
            s_sel_o = s_sel_o | (m_sel_i[SEL_W*i +: SEL_W] & {SEL_W{r_gnt[i]}});
            s_we_o  = s_we_o  | (m_we_i[i] & r_gnt[i]);
        end
    end

    assign w_granted = (r_state == ST_GRANT);
    assign w_cyc_g   = |(m_cyc_i & r_gnt);
    assign w_stb_g   = |(m_stb_i & r_gnt);
    assign w_resp    = s_ack_i | s_err_i | s_rty_i;

    // A slave answer in the timeout cycle wins over the watchdog.
    assign w_to_hit  = w_granted & w_cyc_g & w_stb_g & ~w_resp &
                       (r_cnt == TO_W'(TO_CYC - 1));

    assign s_cyc_o   = w_granted & w_cyc_g;
    assign s_stb_o   = w_granted & w_cyc_g & w_stb_g & ~w_to_hit;

    assign m_dat_o   = s_dat_i;
    assign m_ack_o   = r_gnt & {NM{s_ack_i & s_stb_o}};
    assign m_rty_o   = r_gnt & {NM{s_rty_i & s_stb_o}};
    assign m_err_o   = r_gnt & {NM{(s_err_i & s_stb_o) | w_to_hit}};
    assign gnt_o     = r_gnt;

    // Arbitration FSM: grant held until the owner drops CYC, then a dead cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_last  <= LW'(NM - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_GRANT;
                        r_gnt   <= w_pick;
                    end else begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (!w_cyc_g) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                        r_last  <= w_g;
                    end else begin
                        r_state <= ST_GRANT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    // Per-beat watchdog: counts cycles a strobe waits without any slave answer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!s_stb_o || w_resp) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + TO_W'(1);
        end
    end

endmodule
